// File: rtl/ciclo_lavado.sv
// Wash-cycle sequencer: turns payment grants into timed fill/agitate/rinse/spin/dry phases.
// Define ENCOLAR_EN to add a one-deep pending-grant buffer; by default busy grants are rejected.
module ciclo_lavado #(
    parameter int T_LLENADO  = 2,
    parameter int T_LAVADO   = 4,
    parameter int T_ENJUAGUE = 3,
    parameter int T_CENTRIF  = 2,
    parameter int T_SECADO   = 5,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SECADO,
    input  logic       LAVADO,
    input  logic       LAVADO_PESADO,
    input  logic       puerta_cerrada,
    input  logic       cancelar,
    output logic       ocupado,
    output logic       puerta_bloqueada,
    output logic       llenar,
    output logic       agitar,
    output logic       enjuagar,
    output logic       centrifugar,
    output logic       secar,
    output logic       fin,
    output logic       rechazo,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ESPERA,
        ST_LLENADO,
        ST_LAVADO,
        ST_ENJUAGUE,
        ST_CENTRIF,
        ST_SECADO,
        ST_FIN
    } estado_t;

    typedef enum logic [1:0] {
        M_NINGUNO,
        M_SECADO,
        M_LAVADO,
        M_PESADO
    } modo_t;

    // Counter reload values are length-1: a phase of length L spends L cycles in its state.
    localparam logic [CNT_W-1:0] C_LLENADO    = CNT_W'(T_LLENADO - 1);
    localparam logic [CNT_W-1:0] C_LAVADO     = CNT_W'(T_LAVADO - 1);
    localparam logic [CNT_W-1:0] C_LAVADO_P   = CNT_W'(2 * T_LAVADO - 1);
    localparam logic [CNT_W-1:0] C_ENJUAGUE   = CNT_W'(T_ENJUAGUE - 1);
    localparam logic [CNT_W-1:0] C_ENJUAGUE_P = CNT_W'(2 * T_ENJUAGUE - 1);
    localparam logic [CNT_W-1:0] C_CENTRIF    = CNT_W'(T_CENTRIF - 1);
    localparam logic [CNT_W-1:0] C_SECADO     = CNT_W'(T_SECADO - 1);
    localparam logic [CNT_W-1:0] UNO          = CNT_W'(1);

    estado_t          est, est_n;
    modo_t            modo, modo_n, modo_grant;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             hay_grant;
    logic             rech_n;
    logic             pesado;

`ifdef ENCOLAR_EN
    logic  buf_full, buf_full_n;
    modo_t buf_modo, buf_modo_n;
`endif

    assign estado    = est;
    assign hay_grant = SECADO | LAVADO | LAVADO_PESADO;
    assign pesado    = (modo == M_PESADO);

    always_comb begin
        modo_grant = M_NINGUNO;
        if (LAVADO_PESADO) begin
            modo_grant = M_PESADO;
        end else if (LAVADO) begin
            modo_grant = M_LAVADO;
        end else if (SECADO) begin
            modo_grant = M_SECADO;
        end
    end

    always_comb begin
        est_n  = est;
        modo_n = modo;
        rech_n = 1'b0;
        cnt_n  = (cnt != '0) ? cnt - UNO : '0;
`ifdef ENCOLAR_EN
        buf_full_n = buf_full;
        buf_modo_n = buf_modo;
`endif

        // Grants outside IDLE are busy; the state case below may still clear the buffer.
        if (hay_grant && est != ST_IDLE) begin
`ifdef ENCOLAR_EN
            if (!buf_full) begin
                buf_full_n = 1'b1;
                buf_modo_n = modo_grant;
            end else begin
                rech_n = 1'b1;
            end
`else
            rech_n = 1'b1;
`endif
        end

        unique case (est)
            ST_IDLE: begin
                cnt_n = '0;
                if (hay_grant) begin
                    est_n  = ST_ESPERA;
                    modo_n = modo_grant;
                end
`ifdef ENCOLAR_EN
                else if (buf_full) begin
                    est_n      = ST_ESPERA;
                    modo_n     = buf_modo;
                    buf_full_n = 1'b0;
                end
`endif
            end

            ST_ESPERA: begin
                if (cancelar) begin
                    est_n  = ST_IDLE;
                    modo_n = M_NINGUNO;
`ifdef ENCOLAR_EN
                    buf_full_n = 1'b0;
`endif
                end else if (puerta_cerrada) begin
                    if (modo == M_SECADO) begin
                        est_n = ST_SECADO;
                        cnt_n = C_SECADO;
                    end else begin
                        est_n = ST_LLENADO;
                        cnt_n = C_LLENADO;
                    end
                end
            end

            ST_LLENADO, ST_LAVADO, ST_ENJUAGUE: begin
                if (cancelar) begin
                    // Abort still drains the drum with a full spin.
                    est_n = ST_CENTRIF;
                    cnt_n = C_CENTRIF;
`ifdef ENCOLAR_EN
                    buf_full_n = 1'b0;
`endif
                end else if (cnt == '0) begin
                    if (est == ST_LLENADO) begin
                        est_n = ST_LAVADO;
                        cnt_n = pesado ? C_LAVADO_P : C_LAVADO;
                    end else if (est == ST_LAVADO) begin
                        est_n = ST_ENJUAGUE;
                        cnt_n = pesado ? C_ENJUAGUE_P : C_ENJUAGUE;
                    end else begin
                        est_n = ST_CENTRIF;
                        cnt_n = C_CENTRIF;
                    end
                end
            end

            ST_CENTRIF: begin
                if (cnt == '0) begin
                    est_n = ST_FIN;
                end
            end

            ST_SECADO: begin
                if (cancelar || cnt == '0) begin
                    est_n = ST_FIN;
                    cnt_n = '0;
                end
`ifdef ENCOLAR_EN
                if (cancelar) begin
                    buf_full_n = 1'b0;
                end
`endif
            end

            ST_FIN: begin
                est_n  = ST_IDLE;
                modo_n = M_NINGUNO;
                cnt_n  = '0;
`ifdef ENCOLAR_EN
                if (buf_full) begin
                    est_n      = ST_ESPERA;
                    modo_n     = buf_modo;
                    buf_full_n = 1'b0;
                end
`endif
            end

            default: begin
                est_n  = ST_IDLE;
                modo_n = M_NINGUNO;
                cnt_n  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            est              <= ST_IDLE;
            modo             <= M_NINGUNO;
            cnt              <= '0;
            ocupado          <= 1'b0;
            puerta_bloqueada <= 1'b0;
            llenar           <= 1'b0;
            agitar           <= 1'b0;
            enjuagar         <= 1'b0;
            centrifugar      <= 1'b0;
            secar            <= 1'b0;
            fin              <= 1'b0;
            rechazo          <= 1'b0;
`ifdef ENCOLAR_EN
            buf_full         <= 1'b0;
            buf_modo         <= M_NINGUNO;
`endif
        end else begin
            est              <= est_n;
            modo             <= modo_n;
            cnt              <= cnt_n;
            ocupado          <= (est_n != ST_IDLE);
            puerta_bloqueada <= (est_n == ST_LLENADO) || (est_n == ST_LAVADO) ||
                                (est_n == ST_ENJUAGUE) || (est_n == ST_CENTRIF) ||
                                (est_n == ST_SECADO);
            llenar           <= (est_n == ST_LLENADO);
            agitar           <= (est_n == ST_LAVADO);
            enjuagar         <= (est_n == ST_ENJUAGUE);
            centrifugar      <= (est_n == ST_CENTRIF);
            secar            <= (est_n == ST_SECADO);
            fin              <= (est_n == ST_FIN);
            rechazo          <= rech_n;
`ifdef ENCOLAR_EN
            buf_full         <= buf_full_n;
            buf_modo         <= buf_modo_n;
`endif
        end
    end

endmodule

// File: tb/tb_ciclo_lavado.sv
// Directed bench for ciclo_lavado: per-cycle expected output words queued by the driver,
// checked by an independent monitor one time unit after each rising edge.
module tb_ciclo_lavado;
    localparam int W = 9;

    // Output word: {ocupado, bloqueada, llenar, agitar, enjuagar, centrif, secar, fin, rechazo}
    localparam logic [W-1:0] O_IDLE = 9'b0_0000_0000;
    localparam logic [W-1:0] O_ESP  = 9'b1_0000_0000;
    localparam logic [W-1:0] O_LLEN = 9'b1_1100_0000;
    localparam logic [W-1:0] O_AGI  = 9'b1_1010_0000;
    localparam logic [W-1:0] O_ENJ  = 9'b1_1001_0000;
    localparam logic [W-1:0] O_CEN  = 9'b1_1000_1000;
    localparam logic [W-1:0] O_SEC  = 9'b1_1000_0100;
    localparam logic [W-1:0] O_FIN  = 9'b1_0000_0010;
    localparam logic [W-1:0] O_RECH = 9'b0_0000_0001;

    localparam logic [2:0] G_NONE = 3'b000;
    localparam logic [2:0] G_SEC  = 3'b001;
    localparam logic [2:0] G_LAV  = 3'b010;
    localparam logic [2:0] G_PES  = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic SECADO = 1'b0;
    logic LAVADO = 1'b0;
    logic LAVADO_PESADO = 1'b0;
    logic puerta_cerrada = 1'b1;
    logic cancelar = 1'b0;
    logic ocupado, puerta_bloqueada, llenar, agitar, enjuagar, centrifugar, secar, fin, rechazo;
    logic [2:0] estado;
    logic [W-1:0] salida;
    logic [W-1:0] esperado;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int ciclo = 0;
    string escena = "reset";

    always #5 clk = ~clk;

    ciclo_lavado dut (
        .clk              (clk),
        .rst              (rst),
        .SECADO           (SECADO),
        .LAVADO           (LAVADO),
        .LAVADO_PESADO    (LAVADO_PESADO),
        .puerta_cerrada   (puerta_cerrada),
        .cancelar         (cancelar),
        .ocupado          (ocupado),
        .puerta_bloqueada (puerta_bloqueada),
        .llenar           (llenar),
        .agitar           (agitar),
        .enjuagar         (enjuagar),
        .centrifugar      (centrifugar),
        .secar            (secar),
        .fin              (fin),
        .rechazo          (rechazo),
        .estado           (estado)
    );

    assign salida = {ocupado, puerta_bloqueada, llenar, agitar, enjuagar,
                     centrifugar, secar, fin, rechazo};

    // Monitor: pops one expected word per cycle while the driver has queued any.
    always @(posedge clk) begin
        #1;
        ciclo++;
        if (exp_q.size() != 0) begin
            esperado = exp_q.pop_front();
            checks++;
            if (salida !== esperado) begin
                errors++;
                $display("FAIL %s t=%0t: outputs got %b expected %b", escena, $time, salida, esperado);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic tick(input logic [2:0] g, input logic c, input logic [W-1:0] e);
        {LAVADO_PESADO, LAVADO, SECADO} = g;
        cancelar = c;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run(input logic [W-1:0] e, input int n);
        for (int i = 0; i < n; i++) begin
            tick(G_NONE, 1'b0, e);
        end
    endtask

    task automatic check_now(input string nombre, input logic [W-1:0] e);
        checks++;
        if (salida !== e) begin
            errors++;
            $display("FAIL %s t=%0t: outputs got %b expected %b", nombre, $time, salida, e);
        end
    endtask

    initial begin
        rst = 1'b0;
        puerta_cerrada = 1'b1;
        repeat (2) @(negedge clk);
        check_now("reset_outputs", O_IDLE);
        rst = 1'b1;
        run(O_IDLE, 2);

        escena = "normal_wash";
        tick(G_LAV, 1'b0, O_ESP);
        run(O_LLEN, 2);
        run(O_AGI, 4);
        run(O_ENJ, 3);
        run(O_CEN, 2);
        run(O_FIN, 1);
        run(O_IDLE, 2);

        escena = "heavy_wash_priority";
        tick(G_PES | G_SEC, 1'b0, O_ESP);
        run(O_LLEN, 2);
        run(O_AGI, 8);
        run(O_ENJ, 6);
        run(O_CEN, 2);
        run(O_FIN, 1);
        run(O_IDLE, 1);

        escena = "dry_door_open";
        puerta_cerrada = 1'b0;
        tick(G_SEC, 1'b0, O_ESP);
        run(O_ESP, 2);
        puerta_cerrada = 1'b1;
        run(O_SEC, 5);
        run(O_FIN, 1);
        run(O_IDLE, 1);

        escena = "cancel_mid_wash";
        tick(G_LAV, 1'b0, O_ESP);
        run(O_LLEN, 2);
        run(O_AGI, 2);
        tick(G_NONE, 1'b1, O_CEN);
        run(O_CEN, 1);
        run(O_FIN, 1);
        run(O_IDLE, 1);

        escena = "busy_grant";
        tick(G_LAV, 1'b0, O_ESP);
        run(O_LLEN, 2);
        run(O_AGI, 4);
        run(O_ENJ, 1);
`ifdef ENCOLAR_EN
        tick(G_LAV, 1'b0, O_ENJ);
        tick(G_LAV, 1'b0, O_ENJ | O_RECH);
        run(O_CEN, 2);
        run(O_FIN, 1);
        run(O_ESP, 1);
        run(O_LLEN, 2);
        run(O_AGI, 4);
        run(O_ENJ, 3);
        run(O_CEN, 2);
        run(O_FIN, 1);
        run(O_IDLE, 1);
`else
        tick(G_LAV, 1'b0, O_ENJ | O_RECH);
        run(O_ENJ, 1);
        run(O_CEN, 2);
        run(O_FIN, 1);
        run(O_IDLE, 1);
`endif

        escena = "reset_mid_dry";
        tick(G_SEC, 1'b0, O_ESP);
        run(O_SEC, 2);
        #2;
        rst = 1'b0;
        #1;
        check_now("async_reset_outputs", O_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        escena = "after_reset";
        run(O_IDLE, 1);
        tick(G_LAV, 1'b0, O_ESP);
        run(O_LLEN, 2);
        run(O_AGI, 4);
        run(O_ENJ, 3);
        run(O_CEN, 2);
        run(O_FIN, 1);
        run(O_IDLE, 1);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
